// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage of the 32-bit MIPS pipeline.
// Owns the PC, drives the word-indexed instruction memory address, and
// registers the returned instruction into the IF/ID pipeline register.
// Stalls, redirects and fetches past the end of instruction memory are
// handled here. A fetch past the end parks the unit in HALTED.
// Optional feature: define FETCH_PERF_COUNTERS_EN to add the stall_count
// and flush_count performance counters and their ports.
//
// Handshake: there is no valid/ready pair at this stage. stall is a
// level-sensitive hold from the hazard unit, and redirect is a one-edge
// command that always wins over stall. if_id_valid marks a real
// instruction. When it is 0, the IF/ID contents are a bubble.
// The FSM state is visible on the halted output (1 = HALTED, 0 = RUN).
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
`endif
    output logic        halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] pc_plus4_nxt;
    logic        valid_nxt;
    logic [31:0] pc_plus4;
    logic        out_of_range;

    assign pc_plus4     = pc + 32'd4;
    assign imem_addr    = {2'b00, pc[31:2]};
    assign out_of_range = (pc[31:2] >= DEPTH_WORDS);
    assign halted       = (state == HALTED);

    // Next-state and next IF/ID contents. The order of the checks sets the
    // priority: redirect, then stall, then fetch.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_nxt    = if_id_instr;
        pc_plus4_nxt = if_id_pc_plus4;
        valid_nxt    = if_id_valid;
        if (redirect) begin
            // The low address bits are dropped so the PC stays word aligned.
            // Whatever is on imem_instr this cycle is discarded.
            pc_nxt    = {redirect_pc[31:2], 2'b00};
            instr_nxt = 32'h0;
            valid_nxt = 1'b0;
            state_nxt = RUN;
        end else if (stall) begin
            // Hold everything.
            state_nxt = state;
        end else begin
            case (state)
                RUN: begin
                    if (out_of_range) begin
                        instr_nxt = 32'h0;
                        valid_nxt = 1'b0;
                        state_nxt = HALTED;
                    end else begin
                        instr_nxt    = imem_instr;
                        pc_plus4_nxt = pc_plus4;
                        valid_nxt    = 1'b1;
                        pc_nxt       = pc_plus4;
                    end
                end
                HALTED: begin
                    instr_nxt = 32'h0;
                    valid_nxt = 1'b0;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    // State, PC and IF/ID register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            if_id_instr    <= instr_nxt;
            if_id_pc_plus4 <= pc_plus4_nxt;
            if_id_valid    <= valid_nxt;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    // Performance counters. A stall counts only when no redirect overrides it.
    // Both counters wrap naturally on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 32'h0;
            flush_count <= 32'h0;
        end else begin
            if (stall && !redirect) begin
                stall_count <= stall_count + 32'd1;
            end
            if (redirect) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench for instruction_fetch_unit.
// The bench keeps a behavioural model of the fetch stage built from its
// architectural rules. A negedge compare process checks every output against
// that model. Literal checks at key points pin the model itself.
module tb_instruction_fetch_unit;

    localparam int          DEPTH    = 128;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC   (RST_PC),
        .IMEM_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
`ifdef FETCH_PERF_COUNTERS_EN
        .stall_count    (stall_count),
        .flush_count    (flush_count),
`endif
        .halted         (halted)
    );

    // ---------------- instruction memory ----------------
    logic [31:0] imem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            imem[i] = 32'h1000_0000 + 32'(i * 3);
        end
        imem[0] = 32'h8C25_0003;
        imem[1] = 32'h00A1_2820;
        imem[4] = 32'h2002_0004;
        imem[126] = 32'hAAAA_5555;
        imem[127] = 32'h5555_AAAA;
    end

    assign imem_instr = (imem_addr < 32'(DEPTH)) ? imem[imem_addr[6:0]] : 32'hFFFF_FFFF;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc     = RST_PC;
    logic [31:0] m_instr  = 32'h0;
    logic [31:0] m_pc4    = 32'h0;
    logic        m_valid  = 1'b0;
    logic        m_halted = 1'b0;
    logic [31:0] m_stall_cnt = 32'h0;
    logic [31:0] m_flush_cnt = 32'h0;
    logic [31:0] exp_q[$];
    logic        chk_en = 1'b0;

    // Model update on each rising edge, following the fetch-stage rules directly.
    always @(posedge clk) begin
        if (reset) begin
            m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (stall && !redirect) m_stall_cnt = m_stall_cnt + 1;
            if (redirect) m_flush_cnt = m_flush_cnt + 1;
            if (redirect) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_instr = 0; m_valid = 0; m_halted = 0;
            end else if (stall) begin
                // nothing moves
            end else if (m_halted) begin
                m_instr = 0; m_valid = 0;
            end else if ((m_pc / 4) >= DEPTH) begin
                m_instr = 0; m_valid = 0; m_halted = 1;
            end else begin
                m_instr = imem[m_pc / 4];
                m_pc4   = m_pc + 4;
                m_valid = 1;
                m_pc    = m_pc + 4;
            end
        end
    end

    // Compare process: every cycle after the first edge.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_q.push_back(m_pc);
            check("pc", pc, exp_q.pop_front());
            check("imem_addr", imem_addr, m_pc >> 2);
            check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
            check("if_id_instr", if_id_instr, m_instr);
            if (m_valid) check("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
            check("halted", {31'h0, halted}, {31'h0, m_halted});
`ifdef FETCH_PERF_COUNTERS_EN
            check("stall_count", stall_count, m_stall_cnt);
            check("flush_count", flush_count, m_flush_cnt);
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        reset = r; stall = s; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("lit_reset_pc", pc, 32'h0);
        check("lit_reset_valid", {31'h0, if_id_valid}, 32'h0);
        check("lit_reset_instr", if_id_instr, 32'h0);

        // Reset release: first fetch.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("lit_first_instr", if_id_instr, 32'h8C25_0003);
        check("lit_first_pc4", if_id_pc_plus4, 32'd4);
        check("lit_first_valid", {31'h0, if_id_valid}, 32'd1);
        check("lit_first_pc", pc, 32'd4);

        // Load-use stall for one cycle.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_stall_pc", pc, 32'd4);
        check("lit_stall_instr", if_id_instr, 32'h8C25_0003);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("lit_after_stall_instr", if_id_instr, 32'h00A1_2820);
        check("lit_after_stall_pc4", if_id_pc_plus4, 32'd8);

        // Simultaneous stall + redirect at pc=8: redirect wins.
        step(1'b0, 1'b1, 1'b1, 32'h0);
        check("lit_sr_pc", pc, 32'h0);
        check("lit_sr_valid", {31'h0, if_id_valid}, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
        check("lit_sr_flush", flush_count, 32'd1);
        check("lit_sr_stall", stall_count, 32'd1);
`endif
        run(1);

        // Redirect with misaligned target.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0012);
        check("lit_redir_pc", pc, 32'd16);
        check("lit_redir_instr", if_id_instr, 32'h0);
        check("lit_redir_valid", {31'h0, if_id_valid}, 32'h0);
        run(1);
        check("lit_redir_target", if_id_instr, 32'h2002_0004);
        check("lit_redir_pc4", if_id_pc_plus4, 32'd20);

        // Multi-cycle stall.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        run(2);

        // Run off the end of memory.
        step(1'b0, 1'b0, 1'b1, 32'h0000_01F8);
        run(2);
        check("lit_last_instr", if_id_instr, 32'h5555_AAAA);
        check("lit_last_pc", pc, 32'd512);
        run(1);
        check("lit_halt", {31'h0, halted}, 32'd1);
        check("lit_halt_pc", pc, 32'd512);
        run(2);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_halt_stall", {31'h0, halted}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("lit_unhalt", {31'h0, halted}, 32'd0);
        check("lit_unhalt_pc", pc, 32'h0);
        run(2);

        // Redirect to an out-of-range target halts on the next fetch edge.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0400);
        check("lit_oor_redir_halted", {31'h0, halted}, 32'd0);
        run(1);
        check("lit_oor_halt", {31'h0, halted}, 32'd1);
        check("lit_oor_pc", pc, 32'h0000_0400);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0008);
        run(3);

        // Reset mid-stream with stall and redirect high.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0020);
        check("lit_mid_reset_pc", pc, RST_PC);
        check("lit_mid_reset_valid", {31'h0, if_id_valid}, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
        check("lit_mid_reset_scnt", stall_count, 32'h0);
        check("lit_mid_reset_fcnt", flush_count, 32'h0);
`endif
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
